// File: rtl/spi_dac_mux_pkg.sv
// Shared definitions for the multi-channel SPI DAC driver: FSM encoding,
// DAC command codes and default full-scale calibration constants.
package spi_dac_mux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } state_t;

    localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] DAC_CMD_POWER_DOWN   = 4'b0100;

    localparam int DEF_SCALE_NUM = 4095;
    localparam int DEF_SCALE_DEN = 3312;

    // Channel index width, never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_dac_scaler.sv
// Full-scale calibration for DAC codes: code = min(raw*NUM/DEN, 2^DATA_W-1).
// Purely combinational so other DAC paths can drop it in front of their own registers.
module spi_dac_scaler
    import spi_dac_mux_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int SCALE_NUM = DEF_SCALE_NUM,
    parameter int SCALE_DEN = DEF_SCALE_DEN
) (
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] code
);

    localparam int PW = DATA_W + 16;
    localparam logic [PW-1:0] MAX_CODE = PW'({DATA_W{1'b1}});

    logic [PW-1:0] product;
    logic [PW-1:0] quotient;

    assign product  = PW'(raw) * PW'(SCALE_NUM);
    assign quotient = product / PW'(SCALE_DEN);
    assign code     = (quotient > MAX_CODE) ? {DATA_W{1'b1}} : quotient[DATA_W-1:0];

endmodule

// File: rtl/spi_dac_mux.sv
// Multi-channel SPI DAC driver: captures per-channel writes, calibrates them and
// serialises {CMD, code} frames round-robin to chips sharing SCK/MOSI.
module spi_dac_mux
    import spi_dac_mux_pkg::*;
#(
    parameter int               DATA_W    = 12,
    parameter int               CHANNELS  = 2,
    parameter int               CMD_W     = 4,
    parameter logic [CMD_W-1:0] CMD       = CMD_W'(DAC_CMD_WRITE_UPDATE),
    parameter int               CLK_DIV   = 25,
    parameter int               SCALE_NUM = DEF_SCALE_NUM,
    parameter int               SCALE_DEN = DEF_SCALE_DEN,
    parameter int               SKIP_SAME = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [chan_w(CHANNELS)-1:0]   wr_chan,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          spi_sck,
    output logic                          spi_mosi,
    output logic [CHANNELS-1:0]           spi_cs,
    output logic                          busy,
    output logic                          frame_done,
    output logic [chan_w(CHANNELS)-1:0]   cur_chan
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CW      = chan_w(CHANNELS);
    localparam int DW      = $clog2(CLK_DIV + 1);
    localparam int BW      = $clog2(FRAME_W + 1);

    state_t              state;
    logic [DW-1:0]       div_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [FRAME_W-1:0]  shift_reg;
    logic [DATA_W-1:0]   shadow    [CHANNELS];
    logic [DATA_W-1:0]   last_sent [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CW-1:0]       rr_ptr;

    logic [CW-1:0]       pick;
    logic [CW-1:0]       idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   pick_code;
    logic                wr_take;
    logic                div_done;

    assign div_done = (div_cnt == DW'(CLK_DIV - 1));

    spi_dac_scaler #(
        .DATA_W    (DATA_W),
        .SCALE_NUM (SCALE_NUM),
        .SCALE_DEN (SCALE_DEN)
    ) u_scaler (
        .raw  (shadow[pick]),
        .code (pick_code)
    );

    // Round-robin: scan downward so the channel closest after rr_ptr is assigned last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pick_valid = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            idx = CW'((int'(rr_ptr) + i) % CHANNELS);
            if (pending[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        wr_take = 1'b0;
        if (wr_en && (int'(wr_chan) < CHANNELS)) begin
            wr_take = 1'b1;
            if ((SKIP_SAME != 0) && !pending[wr_chan] && (wr_data == last_sent[wr_chan]))
                wr_take = 1'b0;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            pending    <= '0;
            rr_ptr     <= CW'(CHANNELS - 1);
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs     <= '1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cur_chan   <= '0;
            // NOTE: the per-channel arrays are small register files, not RAM, so they
            // are reset here; SKIP_SAME relies on last_sent starting at a known value.
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c]    <= '0;
                last_sent[c] <= '0;
            end
        end else begin
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        shift_reg       <= {CMD, pick_code};
                        spi_mosi        <= CMD[CMD_W-1];
                        spi_cs          <= ~(CHANNELS'(1) << pick);
                        spi_sck         <= 1'b0;
                        busy            <= 1'b1;
                        cur_chan        <= pick;
                        rr_ptr          <= pick;
                        last_sent[pick] <= shadow[pick];
                        pending[pick]   <= 1'b0;
                        div_cnt         <= '0;
                        bit_cnt         <= '0;
                        state           <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        spi_sck <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SHIFT_HI: begin
                    if (div_done) begin
                        div_cnt   <= '0;
                        spi_sck   <= 1'b0;
                        shift_reg <= shift_reg << 1;
                        spi_mosi  <= shift_reg[FRAME_W-2];
                        bit_cnt   <= bit_cnt + 1'b1;
                        state     <= SHIFT_LO;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SHIFT_LO: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (bit_cnt == BW'(FRAME_W)) begin
                            spi_cs     <= '1;
                            spi_mosi   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= GAP;
                        end else begin
                            spi_sck <= 1'b1;
                            state   <= SHIFT_HI;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase

            // Placed after the FSM so a write landing in the latch cycle keeps pending set.
            if (wr_take) begin
                shadow[wr_chan]  <= wr_data;
                pending[wr_chan] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_dac_mux.sv
// Directed self-checking bench for spi_dac_mux (12-bit, 2 channels, CLK_DIV=2).
module tb_spi_dac_mux;

    localparam int CLK_DIV  = 2;
    localparam int FRAME_W  = 16;
    localparam int CS_LOW   = (2 * FRAME_W + 1) * CLK_DIV;
    // CS stays high for the GAP state plus the one IDLE arbitration cycle.
    localparam int GAP_HIGH = CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [0:0]  wr_chan = '0;
    logic [11:0] wr_data = '0;
    logic        spi_sck;
    logic        spi_mosi;
    logic [1:0]  spi_cs;
    logic        busy;
    logic        frame_done;
    logic [0:0]  cur_chan;

    spi_dac_mux #(
        .DATA_W   (12),
        .CHANNELS (2),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_chan    (wr_chan),
        .wr_data    (wr_data),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .busy       (busy),
        .frame_done (frame_done),
        .cur_chan   (cur_chan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cs;
        logic [15:0] bits;
        int          nbits;
        int          cs_len;
        int          gap;
    } frame_t;

    frame_t      frames[$];
    frame_t      mon_f;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] cap_bits = '0;
    int          cap_n = 0;
    int          cs_len = 0;
    int          gap_len = 0;
    int          gap_before = 0;
    logic [1:0]  cs_mask = '1;
    logic        prev_sck = 1'b0;
    int          multi_cs = 0;

    // Bus monitor: MOSI is taken on each SCK rise, frames are logged on frame_done.
    always @(negedge clk) begin
        if (rst) begin
            cap_bits   = '0;
            cap_n      = 0;
            cs_len     = 0;
            gap_len    = 0;
            gap_before = 0;
            cs_mask    = '1;
            prev_sck   = 1'b0;
        end else begin
            if (spi_sck && !prev_sck) begin
                cap_bits = {cap_bits[14:0], spi_mosi};
                cap_n++;
            end
            prev_sck = spi_sck;
            if (spi_cs == 2'b00) multi_cs++;
            if (spi_cs != 2'b11) begin
                if (cs_len == 0) gap_before = gap_len;
                cs_len++;
                cs_mask = spi_cs;
            end else begin
                gap_len++;
            end
            if (frame_done) begin
                mon_f.cs     = cs_mask;
                mon_f.bits   = cap_bits;
                mon_f.nbits  = cap_n;
                mon_f.cs_len = cs_len;
                mon_f.gap    = gap_before;
                frames.push_back(mon_f);
                cap_n   = 0;
                cs_len  = 0;
                gap_len = 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input int ch, input int val);
        wr_en   = 1'b1;
        wr_chan = 1'(ch);
        wr_data = 12'(val);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [1:0] exp_cs,
                                input logic [15:0] exp_bits, input int exp_gap);
        int     n;
        frame_t f;
        n = 0;
        while (frames.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " present"}, 32'(frames.size() > 0), 32'd1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check({tag, " cs"}, 32'(f.cs), 32'(exp_cs));
            check({tag, " bits"}, 32'(f.bits), 32'(exp_bits));
            check({tag, " nbits"}, 32'(f.nbits), 32'(FRAME_W));
            check({tag, " cs_len"}, 32'(f.cs_len), 32'(CS_LOW));
            check({tag, " cur_chan"}, 32'(cur_chan), (exp_cs == 2'b10) ? 32'd0 : 32'd1);
            if (exp_gap >= 0) check({tag, " gap"}, 32'(f.gap), 32'(exp_gap));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int busy_seen;
        busy_seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check({tag, " busy"}, 32'(busy_seen), 32'd0);
        check({tag, " frames"}, 32'(frames.size()), 32'd0);
        check({tag, " cs"}, 32'(spi_cs), 32'h3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached after %0d vectors", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst cs", 32'(spi_cs), 32'h3);
        check("rst sck", 32'(spi_sck), 32'd0);
        check("rst mosi", 32'(spi_mosi), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst cur_chan", 32'(cur_chan), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero equals the reset last-sent value: skipped
        write(0, 0);
        expect_quiet("zero_after_reset", 100);

        // Full scale on ch0; ch1 overwritten before its frame starts (latest wins)
        write(0, 3312);
        repeat (3) @(negedge clk);
        write(1, 4000);
        write(1, 1656);
        expect_frame("a_ch0", 2'b10, 16'h3FFF, -1);
        expect_frame("a_ch1", 2'b01, 16'h37FF, GAP_HIGH);
        wait_idle("a");
        expect_quiet("a_single", 100);

        // Saturation, then round-robin after ch1 served: ch0 wins
        write(1, 4000);
        repeat (3) @(negedge clk);
        write(1, 200);
        write(0, 100);
        expect_frame("b_sat_ch1", 2'b01, 16'h3FFF, -1);
        expect_frame("b_rr_ch0", 2'b10, 16'h307B, GAP_HIGH);
        expect_frame("b_rr_ch1", 2'b01, 16'h30F7, GAP_HIGH);
        wait_idle("b");

        // Round-robin after ch0 served: ch1 wins
        write(0, 3312);
        repeat (3) @(negedge clk);
        write(0, 1656);
        write(1, 3312);
        expect_frame("c_ch0", 2'b10, 16'h3FFF, -1);
        expect_frame("c_rr_ch1", 2'b01, 16'h3FFF, GAP_HIGH);
        expect_frame("c_rr_ch0", 2'b10, 16'h37FF, GAP_HIGH);
        wait_idle("c");

        // Repeating last-sent values produces no frame
        write(0, 1656);
        write(1, 3312);
        expect_quiet("skip_same", 150);

        // Mid-frame write on the active channel
        write(0, 3312);
        repeat (20) @(negedge clk);
        write(0, 500);
        expect_frame("e_ch0", 2'b10, 16'h3FFF, -1);
        expect_frame("e_ch0_next", 2'b10, 16'h326A, GAP_HIGH);
        wait_idle("e");

        // Asynchronous reset in the middle of shifting
        write(1, 1656);
        repeat (30) @(negedge clk);
        check("f_in_frame busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("f_rst cs", 32'(spi_cs), 32'h3);
        check("f_rst sck", 32'(spi_sck), 32'd0);
        check("f_rst mosi", 32'(spi_mosi), 32'd0);
        check("f_rst busy", 32'(busy), 32'd0);
        check("f_rst cur_chan", 32'(cur_chan), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("f_no_resume", 200);

        check("single_cs", 32'(multi_cs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
